spi_fifo_sequencer: RTL and testbench

Transfer sequencer between the host-side TX FIFO, the `spimaster` engine and the RX FIFO. It pops a byte from the TX FIFO and starts one SPI byte transfer. When the engine returns idle, it captures the received byte and pushes it into the RX FIFO. It replaces free-running glue logic with an explicit go/busy handshake, backpressure from a full RX FIFO, a start timeout and a transfer counter readable over the memory-controller register map.

---
 rtl/spi_fifo_sequencer.sv | 73 +++++++
 tb/tb_spi_fifo_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_fifo_sequencer.sv
// spi_fifo_sequencer: pops TX FIFO bytes into spimaster one at a time and pushes each reply into the RX FIFO
module spi_fifo_sequencer #(
  parameter int START_TIMEOUT = 15,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   rx_discard,
  input  logic                   count_clear,
  input  logic                   err_clear,
  input  logic                   tx_nempty,
  input  logic [7:0]             tx_data,
  output logic                   tx_pop,
  output logic                   spi_go,
  output logic [7:0]             spi_din,
  input  logic                   spi_state,
  input  logic [7:0]             spi_dout,
  input  logic                   rx_full,
  output logic                   rx_shift,
  output logic [7:0]             rx_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] xfer_count,
  output logic                   timeout_err
);
  localparam int TW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, PUSH} state_t;
  state_t                 r_state, w_state_nx;
  logic [TW-1:0]          r_tmo;
  logic                   r_tx_pop, r_spi_go, r_err;
  logic [7:0]             r_spi_din, r_rx_data;
  logic [COUNT_WIDTH-1:0] r_count;
  logic                   w_start, w_started, w_timeout, w_done, w_push_exit;
  always_comb begin
    w_start     = r_state == IDLE && enable && tx_nempty && !spi_state && (rx_discard || !rx_full);
    w_started   = r_state == START && spi_state;
    w_timeout   = r_state == START && !spi_state && r_tmo == TW'(START_TIMEOUT - 1);
    w_done      = r_state == WAIT_DONE && !spi_state;
    w_push_exit = r_state == PUSH && (rx_discard || !rx_full);
    w_state_nx  = w_start ? START : w_started ? WAIT_DONE : w_timeout ? IDLE :
                  w_done ? PUSH : w_push_exit ? IDLE : r_state;
  end
  // r_tmo counts START cycles; it restarts from 0 whenever the FSM is outside START
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_tx_pop  <= 1'b0;
      r_spi_go  <= 1'b0;
      r_spi_din <= '0;
      r_rx_data <= '0;
      r_tmo     <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_tx_pop <= w_start;
      r_spi_go <= w_start || (r_state == START && !spi_state && !w_timeout);
      r_tmo    <= r_state == START ? r_tmo + 1'b1 : '0;
      if (w_start) r_spi_din <= tx_data;
      if (w_done) r_rx_data <= spi_dout;
      r_count  <= count_clear ? '0 : r_count + COUNT_WIDTH'(w_push_exit);
      r_err    <= w_timeout || (r_err && !err_clear);
    end
  end
  assign tx_pop      = r_tx_pop;
  assign spi_go      = r_spi_go;
  assign spi_din     = r_spi_din;
  assign rx_data     = r_rx_data;
  assign rx_shift    = r_state == PUSH && !rx_discard && !rx_full;
  assign busy        = r_state != IDLE;
  assign xfer_count  = r_count;
  assign timeout_err = r_err;
endmodule

// File: tb/tb_spi_fifo_sequencer.sv
// tb_spi_fifo_sequencer: table, directed and random checks of spi_fifo_sequencer against FIFO/engine models
module tb_spi_fifo_sequencer;
  localparam int TMO = 15;
  logic clock = 0, reset = 1, enable = 0, rx_discard = 0, count_clear = 0, err_clear = 0;
  logic tx_nempty = 0, spi_state = 0, rx_full = 0;
  logic [7:0] tx_data = 0, spi_dout = 0;
  logic tx_pop, spi_go, rx_shift, busy, timeout_err;
  logic [7:0] spi_din, rx_data;
  logic [15:0] xfer_count;

  spi_fifo_sequencer #(.START_TIMEOUT(TMO), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx_discard(rx_discard),
    .count_clear(count_clear), .err_clear(err_clear), .tx_nempty(tx_nempty),
    .tx_data(tx_data), .tx_pop(tx_pop), .spi_go(spi_go), .spi_din(spi_din),
    .spi_state(spi_state), .spi_dout(spi_dout), .rx_full(rx_full), .rx_shift(rx_shift),
    .rx_data(rx_data), .busy(busy), .xfer_count(xfer_count), .timeout_err(timeout_err));

  always #5 clock = ~clock;

  typedef struct {logic [7:0] resp; int dly; int len;} eng_t;
  typedef struct {
    logic [7:0] tx; logic [7:0] resp; int dly; int len; logic discard; logic full;
    int exp_push; int exp_inc; int exp_go; logic exp_err;
  } vec_t;

  eng_t eng_q[$], eng_cur, e;
  logic [7:0] tx_q[$], got_q[$], exp_q[$];
  int eng_phase = 0, eng_ctr = 0;
  int pops = 0, pushes = 0, go_cyc = 0, cyc = 0, last_go = -100, min_gap = 1000;
  logic prev_go = 0;
  int tests = 0, fails = 0;
  int b_pops, b_push, b_go;
  logic [15:0] b_cnt;
  bit ok;
  vec_t vt[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  task automatic chk_zero(input string n);
    chk({n, "_ctrl"}, {tx_pop, spi_go, rx_shift, busy, timeout_err}, 0);
    chk({n, "_din"}, spi_din, 0);
    chk({n, "_rx_data"}, rx_data, 0);
    chk({n, "_count"}, xfer_count, 0);
  endtask

  task automatic settle(input string name, input int target_pops);
    bit done = 0;
    for (int k = 0; k < 400 && !done; k++) begin
      tick();
      done = pops >= target_pops && !busy && eng_phase == 0 && tx_q.size() == 0;
    end
    chk(name, done, 1);
  endtask

  // TX FIFO, RX FIFO and spimaster models: inputs change at negedge, outputs sampled just after
  initial forever begin
    @(negedge clock);
    if (eng_phase == 1) begin
      if (eng_ctr == 0) begin spi_state = 1; eng_phase = 2; eng_ctr = eng_cur.len - 1; end
      else eng_ctr--;
    end else if (eng_phase == 2) begin
      if (eng_ctr == 0) begin spi_state = 0; spi_dout = eng_cur.resp; eng_phase = 0; end
      else eng_ctr--;
    end
    tx_nempty = tx_q.size() != 0;
    tx_data = tx_nempty ? tx_q[0] : 8'h00;
    #1;
    cyc++;
    if (tx_pop) begin
      chk("pop_nonempty", tx_q.size() != 0, 1);
      if (tx_q.size() != 0) begin
        chk("din_head", spi_din, tx_q[0]);
        void'(tx_q.pop_front());
      end
      pops++;
    end
    if (rx_shift) begin
      chk("shift_allowed", {rx_full, rx_discard}, 0);
      got_q.push_back(rx_data);
      pushes++;
    end
    if (spi_go) begin
      if (!prev_go && cyc - last_go - 1 < min_gap) min_gap = cyc - last_go - 1;
      go_cyc++;
      last_go = cyc;
    end
    prev_go = spi_go;
    if (spi_go && eng_phase == 0 && eng_q.size() != 0) begin
      eng_cur = eng_q.pop_front();
      eng_ctr = eng_cur.dly;
      eng_phase = 1;
    end
  end

  initial begin
    //        tx     resp   dly len dis full push inc go err
    vt[0] = '{8'hA5, 8'h3C, 0,  16, 0,  0,   1,   1,  2, 0};
    vt[1] = '{8'h00, 8'hFF, 2,  1,  0,  0,   1,   1,  4, 0};
    vt[2] = '{8'hFF, 8'h00, 0,  3,  1,  0,   0,   1,  2, 0};
    vt[3] = '{8'h5A, 8'h81, 5,  8,  1,  1,   0,   1,  7, 0};
    vt[4] = '{8'h7E, 8'h42, 13, 2,  0,  0,   1,   1, 15, 0};
    vt[5] = '{8'h33, 8'h44, 14, 2,  0,  0,   0,   0, 15, 1};
    vt[6] = '{8'hC3, 8'h00, -1, 0,  0,  0,   0,   0, 15, 1};

    reset = 1;
    tick(3);
    chk_zero("reset");
    reset = 0;
    enable = 1;
    tick(2);

    for (int i = 0; i < 7; i++) begin
      rx_discard = vt[i].discard;
      rx_full = vt[i].full;
      b_pops = pops; b_push = pushes; b_go = go_cyc; b_cnt = xfer_count;
      if (vt[i].dly >= 0) begin
        e = '{vt[i].resp, vt[i].dly, vt[i].len};
        eng_q.push_back(e);
      end
      tx_q.push_back(vt[i].tx);
      settle($sformatf("v%0d_settle", i), b_pops + 1);
      chk($sformatf("v%0d_pops", i), pops - b_pops, 1);
      chk($sformatf("v%0d_pushes", i), pushes - b_push, vt[i].exp_push);
      chk($sformatf("v%0d_go_cycles", i), go_cyc - b_go, vt[i].exp_go);
      chk($sformatf("v%0d_count_inc", i), 32'(xfer_count - b_cnt), vt[i].exp_inc);
      chk($sformatf("v%0d_err", i), timeout_err, vt[i].exp_err);
      if (vt[i].exp_push != 0) chk($sformatf("v%0d_rx", i), got_q[got_q.size() - 1], vt[i].resp);
      if (vt[i].exp_err) begin
        err_clear = 1; tick(); err_clear = 0;
        chk($sformatf("v%0d_err_clear", i), timeout_err, 0);
      end
      rx_discard = 0;
      rx_full = 0;
    end

    count_clear = 1; tick(); count_clear = 0;
    chk("count_clear", xfer_count, 0);
    min_gap = 1000; b_pops = pops; b_push = pushes; got_q.delete();
    for (int i = 1; i <= 4; i++) begin
      tx_q.push_back(8'(i));
      e = '{8'(8'h90 + i), i % 3, 2 + i};
      eng_q.push_back(e);
    end
    settle("burst_settle", b_pops + 4);
    chk("burst_pops", pops - b_pops, 4);
    chk("burst_pushes", pushes - b_push, 4);
    for (int j = 0; j < 4 && j < got_q.size(); j++) chk($sformatf("burst_rx%0d", j), got_q[j], 8'h91 + 8'(j));
    chk("burst_count", xfer_count, 4);
    chk("burst_gap_ge2", min_gap >= 2, 1);

    b_pops = pops; b_push = pushes;
    e = '{8'h6C, 0, 3}; eng_q.push_back(e);
    tx_q.push_back(8'hD2);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin tick(); ok = pops == b_pops + 1; end
    chk("bp_started", ok, 1);
    rx_full = 1;
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin tick(); ok = eng_phase == 0; end
    chk("bp_engine_done", ok, 1);
    tick(10);
    chk("bp_no_shift", pushes - b_push, 0);
    chk("bp_busy_hold", busy, 1);
    rx_full = 0; count_clear = 1; tick(); count_clear = 0;
    chk("bp_one_push", pushes - b_push, 1);
    chk("bp_rx", got_q[got_q.size() - 1], 8'h6C);
    chk("clear_beats_inc", xfer_count, 0);
    chk("bp_idle", busy, 0);
    rx_full = 1;
    e = '{8'h11, 1, 2}; eng_q.push_back(e);
    tx_q.push_back(8'h99);
    tick(10);
    chk("full_idle_no_pop", pops - b_pops, 1);
    chk("full_idle_not_busy", busy, 0);
    rx_full = 0;
    settle("full_release_settle", b_pops + 2);
    chk("full_release_push", pushes - b_push, 2);
    chk("full_release_rx", got_q[got_q.size() - 1], 8'h11);
    chk("full_release_count", xfer_count, 1);

    b_go = go_cyc; b_cnt = xfer_count;
    tx_q.push_back(8'h4D);
    ok = 0;
    for (int k = 0; k < 60 && !ok; k++) begin tick(); ok = go_cyc - b_go == TMO - 1; end
    chk("tmo_reached", ok, 1);
    chk("tmo_pre_err", timeout_err, 0);
    err_clear = 1; tick(); err_clear = 0;
    chk("tmo_set_beats_clear", timeout_err, 1);
    chk("tmo_go_cycles", go_cyc - b_go, TMO);
    chk("tmo_go_low_idle", {spi_go, busy}, 0);
    chk("tmo_count_same", xfer_count, b_cnt);
    err_clear = 1; tick(); err_clear = 0;
    chk("tmo_err_clear", timeout_err, 0);

    e = '{8'h77, 0, 20}; eng_q.push_back(e);
    tx_q.push_back(8'hE1);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin tick(); ok = spi_state; end
    chk("rst_engine_busy", ok, 1);
    tick(2);
    chk("rst_in_wait_done", {busy, spi_go}, 2'b10);
    b_push = pushes; b_pops = pops;
    reset = 1; tick(); reset = 0;
    chk_zero("rst_wait");
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin tick(); ok = eng_phase == 0; end
    chk("rst_engine_finished", ok, 1);
    tick(5);
    chk("rst_no_push", pushes - b_push, 0);
    chk("rst_no_pop", pops - b_pops, 0);
    chk("rst_still_idle", busy, 0);

    b_pops = pops; b_push = pushes; b_cnt = xfer_count; got_q.delete();
    for (int i = 0; i < 120; i++) begin
      tx_q.push_back(8'($urandom));
      e = '{8'($urandom), int'($urandom_range(0, TMO - 2)), int'($urandom_range(1, 10))};
      eng_q.push_back(e);
      exp_q.push_back(e.resp);
    end
    ok = 0;
    for (int k = 0; k < 20000 && !ok; k++) begin
      enable = $urandom_range(0, 9) != 0;
      rx_full = $urandom_range(0, 3) == 0;
      tick();
      ok = pushes - b_push == 120;
    end
    enable = 1; rx_full = 0;
    chk("rnd_all_pushed", ok, 1);
    settle("rnd_settle", b_pops + 120);
    chk("rnd_got_size", got_q.size(), exp_q.size());
    for (int j = 0; j < exp_q.size() && j < got_q.size(); j++) chk($sformatf("rnd_rx%0d", j), got_q[j], exp_q[j]);
    chk("rnd_pops", pops - b_pops, 120);
    chk("rnd_count", 32'(xfer_count - b_cnt), 120);
    chk("rnd_no_err", timeout_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
